// File: rtl/bsg_channel_narrow_buffered_pkg.sv
// Shared definitions for the buffered channel narrower.
//
// Contents:
//   els_f      - number of output chunks needed to carry one input word
//   cnt_w_f    - width of the chunk counter for a given chunk count
//   bsg_narrow_order_e - chunk emission order selected by lsb_to_msb_p
//
// Optional feature macro used by the files that import this package:
//   BSG_CHANNEL_NARROW_BUFFERED_LAST_EN
package bsg_channel_narrow_pkg;

    // Chunk order; the numeric values match the lsb_to_msb_p parameter.
    typedef enum logic {
        e_msb_first = 1'b0,
        e_lsb_first = 1'b1
    } bsg_narrow_order_e;

    // Ceiling division: how many width_out chunks cover width_in bits.
    function automatic int els_f(input int width_in, input int width_out);
        return (width_in + width_out - 1) / width_out;
    endfunction

    // A single-chunk word still gets a 1-bit counter so the port never
    // collapses to zero width.
    function automatic int cnt_w_f(input int els);
        return (els <= 1) ? 1 : $clog2(els);
    endfunction

endpackage

// File: rtl/bsg_channel_narrow_buffered_if.sv
// Handshake bundle for bsg_channel_narrow_buffered.
//
// Signals (names are from the narrower's point of view):
//   v_i, data_i, ready_o   - wide input channel (producer -> narrower)
//   v_o, data_o, ready_i   - narrow output channel (narrower -> consumer)
//   last_o                 - final chunk marker, only present when
//                            BSG_CHANNEL_NARROW_BUFFERED_LAST_EN is defined
//
// Modports:
//   slave  - the narrower itself
//   master - the surrounding environment (producer + consumer)
interface bsg_channel_narrow_buffered_if #(
    parameter int width_in_p  = 32,
    parameter int width_out_p = 8
);
    logic                   v_i;
    logic [width_in_p-1:0]  data_i;
    logic                   ready_o;
    logic                   v_o;
    logic [width_out_p-1:0] data_o;
    logic                   ready_i;
`ifdef BSG_CHANNEL_NARROW_BUFFERED_LAST_EN
    logic                   last_o;

    modport slave (
        input  v_i, data_i, ready_i,
        output ready_o, v_o, data_o, last_o
    );

    modport master (
        output v_i, data_i, ready_i,
        input  ready_o, v_o, data_o, last_o
    );
`else
    modport slave (
        input  v_i, data_i, ready_i,
        output ready_o, v_o, data_o
    );

    modport master (
        output v_i, data_i, ready_i,
        input  ready_o, v_o, data_o
    );
`endif

endinterface

// File: rtl/bsg_channel_narrow_buffered_chunk_ctr.sv
// Chunk index counter for the buffered channel narrower.
//
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - asynchronous active-high reset, counter returns to 0
//   clr_i    - synchronous clear back to chunk 0 (has priority over up_i)
//   up_i     - advance to the next chunk
//   cnt_o    - current chunk index
//   last_o   - high while cnt_o addresses the final chunk (els_p-1)
module bsg_channel_narrow_chunk_ctr
    import bsg_channel_narrow_pkg::*;
#(
    parameter int els_p   = 4,
    parameter int cnt_w_p = cnt_w_f(els_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clr_i,
    input  logic               up_i,
    output logic [cnt_w_p-1:0] cnt_o,
    output logic               last_o
);

    localparam logic [cnt_w_p-1:0] last_val_lp = cnt_w_p'(els_p - 1);

    logic [cnt_w_p-1:0] cnt_q;
    logic [cnt_w_p-1:0] cnt_d;

    // The parent never raises up_i on the last chunk, so the counter
    // cannot run past els_p-1 and needs no wrap logic of its own.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (up_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == last_val_lp);

endmodule

// File: rtl/bsg_channel_narrow_buffered.sv
// Buffered channel narrower: takes one width_in_p word per input
// handshake, holds it, and emits it as ceil(width_in_p/width_out_p)
// chunks of width_out_p bits, one per output handshake. A new word may
// load in the same cycle the final chunk of the previous one leaves, so
// a continuously ready consumer sees no bubbles between words.
//
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - asynchronous active-high reset
//   ch       - bsg_channel_narrow_buffered_if.slave handshake bundle
//              (v_i/data_i/ready_o in, v_o/data_o/ready_i out,
//               last_o when BSG_CHANNEL_NARROW_BUFFERED_LAST_EN is defined)
//
// Parameters:
//   width_in_p   - input word width
//   width_out_p  - output chunk width
//   lsb_to_msb_p - 1: least-significant chunk first, 0: most-significant first
//
// Optional feature macro: BSG_CHANNEL_NARROW_BUFFERED_LAST_EN adds last_o,
// high with the final chunk of every word.
module bsg_channel_narrow_buffered
    import bsg_channel_narrow_pkg::*;
#(
    parameter int width_in_p   = 32,
    parameter int width_out_p  = 8,
    parameter int lsb_to_msb_p = 1
) (
    input logic                          clk_i,
    input logic                          reset_i,
    bsg_channel_narrow_buffered_if.slave ch
);

    localparam int els_lp   = els_f(width_in_p, width_out_p);
    localparam int cnt_w_lp = cnt_w_f(els_lp);
    localparam int buf_w_lp = els_lp * width_out_p;

    localparam bsg_narrow_order_e order_lp =
        (lsb_to_msb_p != 0) ? e_lsb_first : e_msb_first;

    logic [els_lp-1:0][width_out_p-1:0] data_q;
    logic [els_lp-1:0][width_out_p-1:0] data_d;
    logic                               full_q;
    logic                               full_d;

    logic [cnt_w_lp-1:0]    cnt;
    logic [cnt_w_lp-1:0]    idx;
    logic                   last;
    logic                   ready;
    logic                   in_fire;
    logic                   out_fire;
    logic                   ctr_clr;
    logic                   ctr_up;
    logic [width_out_p-1:0] chunk;

    // Ready also opens on the last chunk when the consumer is taking it,
    // which is what removes the bubble between words; this makes ready_o
    // combinationally dependent on ready_i.
    assign ready    = ~full_q | (last & ch.ready_i);
    assign in_fire  = ch.v_i & ready;
    assign out_fire = full_q & ch.ready_i;

    // Any new word, or the end of the current one, restarts at chunk 0.
    assign ctr_clr = in_fire | (out_fire & last);
    assign ctr_up  = out_fire & ~last;

    bsg_channel_narrow_chunk_ctr #(
        .els_p   (els_lp),
        .cnt_w_p (cnt_w_lp)
    ) u_chunk_ctr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (ctr_clr),
        .up_i    (ctr_up),
        .cnt_o   (cnt),
        .last_o  (last)
    );

    // A load takes priority over draining: on a simultaneous last chunk
    // and new word the buffer simply stays full with the new word.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_fire) begin
            full_d = 1'b1;
            data_d = buf_w_lp'(ch.data_i);
        end else if (out_fire & last) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    // MSB-first order walks the chunk array from the top down.
    assign idx = (order_lp == e_lsb_first) ? cnt
                                           : (cnt_w_lp'(els_lp - 1) - cnt);

    // Compare-based mux keeps the select width independent of els_lp.
    always_comb begin
        chunk = '0;
        for (int i = 0; i < els_lp; i++) begin
            if (idx == cnt_w_lp'(i)) begin
                chunk = data_q[i];
            end
        end
    end

    assign ch.ready_o = ready;
    assign ch.v_o     = full_q;
    assign ch.data_o  = chunk;

`ifdef BSG_CHANNEL_NARROW_BUFFERED_LAST_EN
    assign ch.last_o = full_q & last;
`endif

endmodule

// File: tb/tb_bsg_channel_narrow_buffered.sv
// Bench for bsg_channel_narrow_buffered. Three instances run side by side:
//   0: 32->8, LSB chunk first
//   1: 32->8, MSB chunk first
//   2: 20->8, LSB chunk first (three chunks, four pad bits)
// The reference model keeps, per instance, a queue of the chunks still
// owed to the consumer; a word is sliced into that queue when the model
// decides it was accepted.
module tb_bsg_channel_narrow_buffered;

    logic clk;
    logic reset_i;

    logic        v_i     [3];
    logic [31:0] data_i  [3];
    logic        ready_i [3];

    logic        v_o_w     [3];
    logic        ready_o_w [3];
    logic [7:0]  data_o_w  [3];
    logic        last_o_w  [3];

    logic [7:0] mq [3][$];
    logic       accepted [3];

    int vectors;
    int miscompares;

    bsg_channel_narrow_buffered_if #(.width_in_p(32), .width_out_p(8)) if_a ();
    bsg_channel_narrow_buffered_if #(.width_in_p(32), .width_out_p(8)) if_b ();
    bsg_channel_narrow_buffered_if #(.width_in_p(20), .width_out_p(8)) if_c ();

    bsg_channel_narrow_buffered #(.width_in_p(32), .width_out_p(8), .lsb_to_msb_p(1)) u_dut_a (
        .clk_i   (clk),
        .reset_i (reset_i),
        .ch      (if_a.slave)
    );

    bsg_channel_narrow_buffered #(.width_in_p(32), .width_out_p(8), .lsb_to_msb_p(0)) u_dut_b (
        .clk_i   (clk),
        .reset_i (reset_i),
        .ch      (if_b.slave)
    );

    bsg_channel_narrow_buffered #(.width_in_p(20), .width_out_p(8), .lsb_to_msb_p(1)) u_dut_c (
        .clk_i   (clk),
        .reset_i (reset_i),
        .ch      (if_c.slave)
    );

    assign if_a.v_i     = v_i[0];
    assign if_b.v_i     = v_i[1];
    assign if_c.v_i     = v_i[2];
    assign if_a.data_i  = data_i[0];
    assign if_b.data_i  = data_i[1];
    assign if_c.data_i  = data_i[2][19:0];
    assign if_a.ready_i = ready_i[0];
    assign if_b.ready_i = ready_i[1];
    assign if_c.ready_i = ready_i[2];

    assign v_o_w[0]     = if_a.v_o;
    assign v_o_w[1]     = if_b.v_o;
    assign v_o_w[2]     = if_c.v_o;
    assign ready_o_w[0] = if_a.ready_o;
    assign ready_o_w[1] = if_b.ready_o;
    assign ready_o_w[2] = if_c.ready_o;
    assign data_o_w[0]  = if_a.data_o;
    assign data_o_w[1]  = if_b.data_o;
    assign data_o_w[2]  = if_c.data_o;

`ifdef BSG_CHANNEL_NARROW_BUFFERED_LAST_EN
    assign last_o_w[0] = if_a.last_o;
    assign last_o_w[1] = if_b.last_o;
    assign last_o_w[2] = if_c.last_o;
`else
    assign last_o_w[0] = 1'b0;
    assign last_o_w[1] = 1'b0;
    assign last_o_w[2] = 1'b0;
`endif

    // 10-unit clock; inputs change on the falling edge, away from sampling.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slice a word into the chunks the consumer should see, in order.
    function automatic void push_word(input int k, input logic [31:0] w);
        int          win;
        int          els;
        int          pos;
        logic [63:0] word;
        win  = (k == 2) ? 20 : 32;
        els  = (win + 7) / 8;
        word = {32'b0, w} & ((64'd1 << win) - 64'd1);
        for (int j = 0; j < els; j++) begin
            pos = (k == 1) ? (els - 1 - j) : j;
            mq[k].push_back(8'(word >> (8 * pos)));
        end
    endfunction

    // Drive the same handshake inputs into all three instances.
    task automatic apply_stimulus(input logic v, input logic [31:0] da, input logic [31:0] dc, input logic r);
        for (int k = 0; k < 3; k++) begin
            v_i[k]     = v;
            ready_i[k] = r;
        end
        data_i[0] = da;
        data_i[1] = da;
        data_i[2] = dc;
    endtask

    // Called 1 unit after the falling edge: compare outputs against the
    // model, advance the model across the next rising edge, then wait for
    // the following falling edge.
    task automatic model_cycle();
        for (int k = 0; k < 3; k++) begin
            int   n;
            logic exp_ready;
            n         = mq[k].size();
            exp_ready = (n == 0) || (n == 1 && ready_i[k]);
            check_output($sformatf("v_o[%0d]", k), 32'(v_o_w[k]), 32'(n != 0));
            check_output($sformatf("ready_o[%0d]", k), 32'(ready_o_w[k]), 32'(exp_ready));
            if (n != 0) begin
                check_output($sformatf("data_o[%0d]", k), 32'(data_o_w[k]), 32'(mq[k][0]));
            end
`ifdef BSG_CHANNEL_NARROW_BUFFERED_LAST_EN
            check_output($sformatf("last_o[%0d]", k), 32'(last_o_w[k]), 32'(n == 1));
`endif
            accepted[k] = v_i[k] && exp_ready;
            if (n != 0 && ready_i[k]) begin
                void'(mq[k].pop_front());
            end
            if (accepted[k]) begin
                push_word(k, data_i[k]);
            end
        end
        @(negedge clk);
    endtask

    // Assert reset at a falling edge, check the immediate reset outputs,
    // and release it on the next falling edge.
    task automatic do_reset();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
        reset_i = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("rst_v_o[%0d]", k), 32'(v_o_w[k]), 32'd0);
            check_output($sformatf("rst_ready_o[%0d]", k), 32'(ready_o_w[k]), 32'd1);
            check_output($sformatf("rst_data_o[%0d]", k), 32'(data_o_w[k]), 32'd0);
`ifdef BSG_CHANNEL_NARROW_BUFFERED_LAST_EN
            check_output($sformatf("rst_last_o[%0d]", k), 32'(last_o_w[k]), 32'd0);
`endif
            mq[k].delete();
            accepted[k] = 1'b0;
        end
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        logic [7:0] ec [4];
        logic [7:0] e2 [8];
        logic       rp [6];
        logic       pending [3];

        vectors     = 0;
        miscompares = 0;
        reset_i     = 1'b1;
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        do_reset();

        // Single word, consumer always ready: chunk order per instance.
        ea = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        eb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        ec = '{8'hDE, 8'hBC, 8'h0A, 8'h00};
        apply_stimulus(1'b1, 32'hAABBCCDD, 32'h000ABCDE, 1'b1);
        #1;
        model_cycle();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
            #1;
            check_output("t1_v_o_a", 32'(v_o_w[0]), 32'(i < 4));
            check_output("t1_v_o_c", 32'(v_o_w[2]), 32'(i < 3));
            if (i < 4) begin
                check_output("t1_data_a", 32'(data_o_w[0]), 32'(ea[i]));
                check_output("t1_data_b", 32'(data_o_w[1]), 32'(eb[i]));
            end
            if (i < 3) begin
                check_output("t1_data_c", 32'(data_o_w[2]), 32'(ec[i]));
            end
`ifdef BSG_CHANNEL_NARROW_BUFFERED_LAST_EN
            check_output("t1_last_c", 32'(last_o_w[2]), 32'(i == 2));
`endif
            model_cycle();
        end

        // Back-to-back words: second word loads as the last chunk leaves.
        e2 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        apply_stimulus(1'b1, 32'h11223344, 32'h00023344, 1'b1);
        #1;
        model_cycle();
        for (int k = 0; k < 3; k++) pending[k] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b0, 32'h55667788, 32'h00067788, 1'b1);
            for (int k = 0; k < 3; k++) v_i[k] = pending[k];
            #1;
            check_output("t2_v_o_a", 32'(v_o_w[0]), 32'(i < 8));
            if (i < 8) begin
                check_output("t2_data_a", 32'(data_o_w[0]), 32'(e2[i]));
            end
            if (i == 3) begin
                check_output("t2_ready_o_a_on_last", 32'(ready_o_w[0]), 32'd1);
            end
            model_cycle();
            for (int k = 0; k < 3; k++) begin
                if (accepted[k]) pending[k] = 1'b0;
            end
        end

        // Consumer stalls mid-word: the held chunk must not change.
        rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_stimulus(1'b1, 32'h01020304, 32'h00020304, 1'b1);
        #1;
        model_cycle();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 32'h0, 32'h0, rp[i]);
            #1;
            if (i == 1 || i == 2) begin
                check_output("t3_stall_data_a", 32'(data_o_w[0]), 32'h03);
            end
            check_output("t3_ready_o_a", 32'(ready_o_w[0]), 32'(i == 5));
            model_cycle();
        end

        // Reset in the middle of a word discards the remaining chunks.
        apply_stimulus(1'b1, 32'hAABBCCDD, 32'h000ABCDE, 1'b1);
        #1;
        model_cycle();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        model_cycle();
        do_reset();
        apply_stimulus(1'b1, 32'h12345678, 32'h00045678, 1'b1);
        #1;
        model_cycle();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        check_output("t4_first_a", 32'(data_o_w[0]), 32'h78);
        check_output("t4_first_b", 32'(data_o_w[1]), 32'h12);
        check_output("t4_first_c", 32'(data_o_w[2]), 32'h78);
        model_cycle();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
            #1;
            model_cycle();
        end

        // Random traffic; a producer holds its word until it is taken.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!(v_i[k] && !accepted[k])) begin
                    v_i[k]    = ($urandom_range(0, 3) != 0);
                    data_i[k] = $urandom;
                end
                ready_i[k] = ($urandom_range(0, 3) != 0);
            end
            #1;
            model_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bsg_channel_narrow_buffered.md
Name: bsg_channel_narrow_buffered

Overview:
- Parametrised successor to the fixed-width channel narrower.
- Accepts one width_in_p word per valid/ready handshake and holds it in an internal register.
- Emits the word as ceil(width_in_p/width_out_p) width_out_p-wide chunks, one per output handshake, in a selectable chunk order.
- Sits between a wide producer FIFO and a narrow link or serializer. Zero-bubble: a new word can be accepted in the same cycle the last chunk of the current word leaves.

Parameters:
- width_in_p, 32, input word width (>=1).
- width_out_p, 8, output chunk width (>=1).
- lsb_to_msb_p, 1, 1 = least-significant chunk first; 0 = most-significant chunk first.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- v_i  in  1  input word valid.
- data_i  in  width_in_p  input word.
- ready_o  out  1  block can accept data_i this cycle.
- v_o  out  1  output chunk valid.
- data_o  out  width_out_p  current output chunk.
- ready_i  in  1  consumer accepts data_o this cycle.

Behaviour:
- Derived constants:
  - els_lp = ceil(width_in_p/width_out_p).
  - cnt_w_lp = max(1, clog2(els_lp)).
  - pad_lp = els_lp*width_out_p - width_in_p. The stored word is zero-extended by pad_lp bits at the MSB end.
- State:
  - full_r (1b).
  - cnt_r (cnt_w_lp b).
  - data_r (els_lp*width_out_p b).
- Reset (async assert, sampled deassert): full_r=0, cnt_r=0, data_r=0. Outputs: v_o=0, ready_o=1, data_o=0.
- Handshakes: in_fire = v_i & ready_o; out_fire = v_o & ready_i.
- v_o = full_r.
- last = (cnt_r == els_lp-1).
- ready_o = ~full_r | (last & ready_i). This combinational path from ready_i is intentional.
- Chunk selection: index = lsb_to_msb_p ? cnt_r : els_lp-1-cnt_r. data_o = data_r[index*width_out_p +: width_out_p].
- Register updates:
  - in_fire: data_r <= zero-extended data_i; full_r <= 1; cnt_r <= 0.
  - out_fire & ~last: cnt_r <= cnt_r+1.
  - out_fire & last & ~in_fire: full_r <= 0; cnt_r <= 0.
  - out_fire & last & in_fire (simultaneous): the new word loads, full_r stays 1, cnt_r <= 0. No bubble.
  - No fire: all state holds. data_o must stay stable while v_o=1 and ready_i=0.
- Latency: first chunk is valid 1 cycle after in_fire.
- Throughput: one word per els_lp cycles when ready_i is held high.
- els_lp=1 (width_in_p <= width_out_p): the block acts as a 1-deep registered pipe with zero-extended output. cnt_r is constant 0 and last is always 1.
- v_i while full and not on the last chunk: the input is not accepted (ready_o=0); the producer must hold data_i.
- ready_i while empty: no effect.
- Reset asserted mid-word: remaining chunks are discarded and state returns to reset values immediately.

Optional Feature:
- Macro: BSG_CHANNEL_NARROW_BUFFERED_LAST_EN.
- When defined: adds output port last_o (1b) = v_o & last, marking the final chunk of each word. Reset value 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package bsg_channel_narrow_pkg holds:
  - function els_f(width_in, width_out) returning the ceiling division.
  - typedef bsg_narrow_order_e {e_lsb_first=1, e_msb_first=0}, used to document lsb_to_msb_p.
- One sub-module: bsg_channel_narrow_chunk_ctr, a cnt_w_lp-bit up-counter.
  - Inputs: clr_i, up_i, async reset.
  - Outputs: cnt_o and last_o at els_lp-1.
- Top-level holds the data register, the chunk mux and the handshake logic.

Test Plan:
- 32->8, lsb_to_msb_p=1, ready_i=1, word 0xAABBCCDD:
  - data_o = 0xDD, 0xCC, 0xBB, 0xAA on 4 consecutive cycles starting 1 cycle after in_fire.
  - v_o low afterwards.
- Same word with lsb_to_msb_p=0 -> data_o = 0xAA, 0xBB, 0xCC, 0xDD.
- 32->8, two back-to-back words 0x11223344 then 0x55667788, ready_i=1:
  - second in_fire coincides with the cycle 0x11 is accepted.
  - 8 consecutive valid cycles, no bubble.
- ready_i toggled 1,0,0,1,1,1 on word 0x01020304 -> data_o holds 0x03 during the stall cycles; ready_o stays 0 until the last chunk fires.
- 20->8 (els_lp=3, pad_lp=4), word 0xABCDE -> data_o = 0xDE, 0xBC, 0x0A. With BSG_CHANNEL_NARROW_BUFFERED_LAST_EN defined, last_o=1 only on 0x0A.
- Reset asserted after chunk 1 of 0xAABBCCDD -> v_o=0 and ready_o=1 immediately. A next word 0x12345678 then emits 0x78 first.
